gpio_irq: RTL and testbench

GPIO_IRQ -- requirements
Module: gpio_irq

---
 rtl/gpio_irq_pkg.sv | 18 +
 rtl/gpio_irq_debounce.sv | 46 ++++
 rtl/gpio_irq.sv | 137 +++++++++++++
 tb/tb_gpio_irq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/gpio_irq_pkg.sv
// gpio_irq shared definitions.
// Register offsets and default parameter values.
package gpio_irq_pkg;

    localparam logic [2:0] REG_DATA  = 3'd0;
    localparam logic [2:0] REG_OE    = 3'd1;
    localparam logic [2:0] REG_SET   = 3'd2;
    localparam logic [2:0] REG_CLR   = 3'd3;
    localparam logic [2:0] REG_IEN   = 3'd4;
    localparam logic [2:0] REG_IPOL  = 3'd5;
    localparam logic [2:0] REG_ISTAT = 3'd6;
    localparam logic [2:0] REG_RSVD  = 3'd7;

    localparam int DEF_WIDTH           = 8;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 25000;

endpackage

// File: rtl/gpio_irq_debounce.sv
// gpio_debounce: single-bit stability filter.
// Output follows input after DEBOUNCE_CYCLES consecutive differing cycles.
import gpio_irq_pkg::*;

module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (d != filt_q) begin
            if (cnt_q == LAST) begin
                filt_d = d;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Filter state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign q = filt_q;

endmodule

// File: rtl/gpio_irq.sv
// gpio_irq: GPIO block with synchronized inputs and edge interrupts.
// Optional per-pin debounce enabled by defining GPIO_IRQ_DEBOUNCE_EN.
import gpio_irq_pkg::*;

module gpio_irq #(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic             wr,
    input  logic             rd,
    input  logic [2:0]       regadr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic [WIDTH-1:0] gp_out,
    output logic [WIDTH-1:0] gp_oe,
    input  logic [WIDTH-1:0] gp_in,
    output logic             irq
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] oe_q, oe_d;
    logic [WIDTH-1:0] ien_q, ien_d;
    logic [WIDTH-1:0] ipol_q, ipol_d;
    logic [WIDTH-1:0] istat_q, istat_d;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] wd;
    logic             irq_q, irq_d;
    logic             we;

    // rd has no side effects; upper wdata bits are ignored when WIDTH < 32.
    logic unused_ok;
    assign unused_ok = ^{rd, wdata};

    assign we = sel & wr;
    assign wd = wdata[WIDTH-1:0];

    // Shift raw pins into the synchronizer chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], gp_in};
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_IRQ_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk(clk),
            .rst(rst),
            .d  (sync_out[i]),
            .q  (filt[i])
        );
    end
`else
    assign filt = sync_out;
`endif

    // Edge detect against the previous filtered value.
    always_comb begin
        evt = ien_q & ((ipol_q & filt & ~prev_q) | (~ipol_q & ~filt & prev_q));
    end

    // Register writes; a new event wins over a same-cycle W1C.
    always_comb begin
        out_d   = out_q;
        oe_d    = oe_q;
        ien_d   = ien_q;
        ipol_d  = ipol_q;
        istat_d = istat_q;
        if (we) begin
            case (regadr)
                REG_DATA:  out_d   = wd;
                REG_OE:    oe_d    = wd;
                REG_SET:   out_d   = out_q | wd;
                REG_CLR:   out_d   = out_q & ~wd;
                REG_IEN:   ien_d   = wd;
                REG_IPOL:  ipol_d  = wd;
                REG_ISTAT: istat_d = istat_q & ~wd;
                default:   ;
            endcase
        end
        istat_d = istat_d | evt;
        irq_d   = |(istat_q & ien_q);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            prev_q  <= '0;
            out_q   <= '0;
            oe_q    <= '0;
            ien_q   <= '0;
            ipol_q  <= '0;
            istat_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= filt;
            out_q   <= out_d;
            oe_q    <= oe_d;
            ien_q   <= ien_d;
            ipol_q  <= ipol_d;
            istat_q <= istat_d;
            irq_q   <= irq_d;
        end
    end

    // Combinational read mux, zero when not selected.
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (regadr)
                REG_DATA:  rdata[WIDTH-1:0] = filt;
                REG_OE:    rdata[WIDTH-1:0] = oe_q;
                REG_IEN:   rdata[WIDTH-1:0] = ien_q;
                REG_IPOL:  rdata[WIDTH-1:0] = ipol_q;
                REG_ISTAT: rdata[WIDTH-1:0] = istat_q;
                default:   rdata = '0;
            endcase
        end
    end

    assign gp_out = out_q;
    assign gp_oe  = oe_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_gpio_irq.sv
// tb_gpio_irq: directed self-checking bench for gpio_irq.
// Debounce vectors run when GPIO_IRQ_DEBOUNCE_EN is defined.
module tb_gpio_irq;
    import gpio_irq_pkg::*;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int DB = 4;
`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam int LAT = SS + DB;
`else
    localparam int LAT = SS;
`endif
    localparam int SETTLE = LAT + 6;

    logic         clk;
    logic         rst;
    logic         sel;
    logic         wr;
    logic         rd;
    logic [2:0]   regadr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic [W-1:0] gp_out;
    logic [W-1:0] gp_oe;
    logic [W-1:0] gp_in;
    logic         irq;
    logic [31:0]  v;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_irq #(
        .WIDTH          (W),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sel   (sel),
        .wr    (wr),
        .rd    (rd),
        .regadr(regadr),
        .wdata (wdata),
        .rdata (rdata),
        .gp_out(gp_out),
        .gp_oe (gp_oe),
        .gp_in (gp_in),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; wr = 1'b1; regadr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; wr = 1'b0; wdata = '0;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
        sel = 1'b1; rd = 1'b1; regadr = a;
        #1;
        d = rdata;
        sel = 1'b0; rd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; sel = 1'b0; wr = 1'b0; rd = 1'b0;
        regadr = '0; wdata = '0; gp_in = '0;
        idle(3);
        check("rst_gp_out", 32'(gp_out), 32'h0);
        check("rst_gp_oe", 32'(gp_oe), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rd_reg(REG_ISTAT, v); check("rst_istat", v, 32'h0);
        rst = 1'b1;

        // Register access
        wr_reg(REG_OE, 32'hA5);
        wr_reg(REG_SET, 32'h0F);
        wr_reg(REG_CLR, 32'h03);
        rd_reg(REG_OE, v);  check("oe_read", v, 32'hA5);
        check("gp_oe", 32'(gp_oe), 32'hA5);
        check("gp_out_setclr", 32'(gp_out), 32'h0C);
        rd_reg(REG_SET, v); check("set_reads0", v, 32'h0);
        rd_reg(REG_CLR, v); check("clr_reads0", v, 32'h0);
        wr_reg(REG_OE, 32'hFFFF_FF5A);
        rd_reg(REG_OE, v);  check("oe_upper0", v, 32'h5A);
        wr_reg(REG_RSVD, 32'hFFFF_FFFF);
        rd_reg(REG_RSVD, v); check("rsvd_read", v, 32'h0);
        regadr = REG_OE; sel = 1'b0; #1;
        check("nosel_rdata", rdata, 32'h0);
        @(negedge clk); wr = 1'b1; regadr = REG_OE; wdata = 32'h33;
        @(negedge clk); wr = 1'b0;
        check("nosel_write", 32'(gp_oe), 32'h5A);
        wr_reg(REG_DATA, 32'h3C);
        check("data_write", 32'(gp_out), 32'h3C);
        wr_reg(REG_IPOL, 32'h01);
        wr_reg(REG_IEN, 32'h01);
        rd_reg(REG_IPOL, v); check("ipol_read", v, 32'h01);
        rd_reg(REG_IEN, v);  check("ien_read", v, 32'h01);

        // Rising edge latency on bit 0
        @(negedge clk); gp_in = 8'h01;
        idle(LAT);
        rd_reg(REG_ISTAT, v); check("rise_istat_early", v, 32'h0);
        @(negedge clk);
        rd_reg(REG_ISTAT, v); check("rise_istat", v, 32'h01);
        check("rise_irq_early", 32'(irq), 32'h0);
        @(negedge clk);
        check("rise_irq", 32'(irq), 32'h1);
        rd_reg(REG_DATA, v); check("data_filt", v, 32'h01);
        wr_reg(REG_ISTAT, 32'h01);
        rd_reg(REG_ISTAT, v); check("w1c_istat", v, 32'h0);
        check("w1c_irq_lag", 32'(irq), 32'h1);
        @(negedge clk);
        check("w1c_irq_drop", 32'(irq), 32'h0);

        // Falling edges, bit 2 disabled
        wr_reg(REG_IEN, 32'h0);
        gp_in = 8'h07;
        idle(SETTLE);
        wr_reg(REG_ISTAT, 32'hFF);
        wr_reg(REG_IPOL, 32'h0);
        wr_reg(REG_IEN, 32'h02);
        gp_in = 8'h01;
        idle(SETTLE);
        rd_reg(REG_ISTAT, v); check("fall_istat", v, 32'h02);
        check("fall_irq", 32'(irq), 32'h1);
        wr_reg(REG_IEN, 32'h0);
        @(negedge clk);
        check("ien_off_irq", 32'(irq), 32'h0);
        rd_reg(REG_ISTAT, v); check("ien_off_istat", v, 32'h02);
        wr_reg(REG_ISTAT, 32'hFF);

        // W1C colliding with a new edge
        wr_reg(REG_IPOL, 32'h01);
        wr_reg(REG_IEN, 32'h01);
        gp_in = 8'h00;
        idle(SETTLE);
        rd_reg(REG_ISTAT, v); check("fall_ignored", v, 32'h0);
        gp_in = 8'h01;
        idle(SETTLE);
        gp_in = 8'h00;
        idle(SETTLE);
        check("pre_coll_irq", 32'(irq), 32'h1);
        @(negedge clk); gp_in = 8'h01;
        idle(LAT);
        sel = 1'b1; wr = 1'b1; regadr = REG_ISTAT; wdata = 32'h01;
        @(negedge clk);
        sel = 1'b0; wr = 1'b0; wdata = '0;
        rd_reg(REG_ISTAT, v); check("coll_istat", v, 32'h01);
        @(negedge clk);
        check("coll_irq", 32'(irq), 32'h1);
        wr_reg(REG_ISTAT, 32'h01);
        rd_reg(REG_ISTAT, v); check("post_coll_clr", v, 32'h0);

        // Asynchronous reset mid-operation
        wr_reg(REG_DATA, 32'hFF);
        wr_reg(REG_IPOL, 32'h0);
        gp_in = 8'h00;
        idle(SETTLE);
        check("pre_rst_irq", 32'(irq), 32'h1);
        check("pre_rst_out", 32'(gp_out), 32'hFF);
        #2 rst = 1'b0;
        #1;
        check("arst_gp_out", 32'(gp_out), 32'h0);
        check("arst_gp_oe", 32'(gp_oe), 32'h0);
        check("arst_irq", 32'(irq), 32'h0);
        rd_reg(REG_IEN, v);   check("arst_ien", v, 32'h0);
        rd_reg(REG_ISTAT, v); check("arst_istat", v, 32'h0);
        @(negedge clk);
        sel = 1'b1; wr = 1'b1; regadr = REG_DATA; wdata = 32'h55;
        @(negedge clk);
        sel = 1'b0; wr = 1'b0;
        rst = 1'b1;
        check("rst_write_drop", 32'(gp_out), 32'h0);
        wr_reg(REG_DATA, 32'h3C);
        check("post_rst_write", 32'(gp_out), 32'h3C);

`ifdef GPIO_IRQ_DEBOUNCE_EN
        // Debounce: short glitch filtered, long pulse accepted
        wr_reg(REG_IPOL, 32'h01);
        wr_reg(REG_IEN, 32'h01);
        idle(SETTLE);
        @(negedge clk); gp_in = 8'h01;
        idle(3);
        gp_in = 8'h00;
        idle(SETTLE);
        rd_reg(REG_ISTAT, v); check("db_glitch", v, 32'h0);
        @(negedge clk); gp_in = 8'h01;
        idle(6);
        gp_in = 8'h00;
        idle(SETTLE);
        rd_reg(REG_ISTAT, v); check("db_pulse", v, 32'h01);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
